// File: rtl/result_drain.sv
`default_nettype none
// ============================================================================
// Module     : result_drain
// Description: Snapshots an NxN result matrix on start and streams it out
//              row-major over valid/ready. Optional running checksum of the
//              accepted beats is enabled by defining RESULT_DRAIN_CHECKSUM_EN.
// Revision   : 1.0  initial release
// ============================================================================
module result_drain #(
  parameter int N  = 8,
  parameter int DW = 16
) (
  input  logic                   m_clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [N*N*DW-1:0]      c_flat,
  output logic [DW-1:0]          out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(N)-1:0]   out_row,
  output logic [$clog2(N)-1:0]   out_col,
  output logic                   out_last,
  output logic                   busy,
`ifdef RESULT_DRAIN_CHECKSUM_EN
  output logic [DW-1:0]          out_checksum,
`endif
  output logic                   done
);

  localparam int c_LN = $clog2(N);
  localparam int c_IW = 2 * c_LN;
  localparam int c_NN = N * N;
  localparam logic [c_IW-1:0] c_LAST_IDX = c_IW'(c_NN - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t            state_q;
  logic [DW-1:0]     snap_q [c_NN];
  logic [c_IW-1:0]   idx_q;
  logic [c_IW-1:0]   idx_d;
  logic [DW-1:0]     data_q;
  logic [c_LN-1:0]   row_q;
  logic [c_LN-1:0]   col_q;
  logic              valid_q;
  logic              last_q;
  logic              busy_q;
  logic              done_q;
  logic              w_beat;

  assign w_beat = valid_q & out_ready;
  assign idx_d  = idx_q + 1'b1;

  // N is a power of two, so row/col are just the upper/lower halves of the index.
  always_ff @(posedge m_clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      for (int i = 0; i < c_NN; i++) snap_q[i] <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            for (int i = 0; i < c_NN; i++) snap_q[i] <= c_flat[DW*i +: DW];
            idx_q   <= '0;
            data_q  <= c_flat[DW-1:0];
            row_q   <= '0;
            col_q   <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_beat) begin
            if (idx_q == c_LAST_IDX) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              idx_q  <= idx_d;
              data_q <= snap_q[idx_d];
              row_q  <= idx_d[c_IW-1:c_LN];
              col_q  <= idx_d[c_LN-1:0];
              last_q <= (idx_d == c_LAST_IDX);
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign out_last  = last_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef RESULT_DRAIN_CHECKSUM_EN
  logic [DW-1:0] sum_q;

  // Wraps mod 2^DW; holds its final value through DONE until the next capture.
  always_ff @(posedge m_clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      sum_q <= '0;
    end else if (state_q == S_STREAM && w_beat) begin
      sum_q <= sum_q + data_q;
    end
  end

  assign out_checksum = sum_q;
`else
  // Default build: no checksum register or adder.
`endif

endmodule
`default_nettype wire

// File: tb/tb_result_drain.sv
`default_nettype none
// Testbench for result_drain: randomized frames and ready patterns checked
// against a frame-snapshot reference model.
module tb_result_drain;
  localparam int N  = 8;
  localparam int DW = 16;
  localparam int NN = N * N;
  localparam int LN = $clog2(N);

  logic              m_clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              out_ready = 1'b0;
  logic [NN*DW-1:0]  c_flat = '0;
  logic [DW-1:0]     out_data;
  logic              out_valid;
  logic [LN-1:0]     out_row;
  logic [LN-1:0]     out_col;
  logic              out_last;
  logic              busy;
  logic              done;
`ifdef RESULT_DRAIN_CHECKSUM_EN
  logic [DW-1:0]     out_checksum;
  logic [DW-1:0]     cs_at_done;
`endif

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] exp_mem [NN];
  logic [DW-1:0] bq_data [$];
  int            bq_row  [$];
  int            bq_col  [$];
  bit            bq_last [$];
  int done_cyc, done_cnt, stab_err, stall_hits;

  result_drain #(.N(N), .DW(DW)) dut (
    .m_clk       (m_clk),
    .rst         (rst),
    .start       (start),
    .c_flat      (c_flat),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_row     (out_row),
    .out_col     (out_col),
    .out_last    (out_last),
    .busy        (busy),
`ifdef RESULT_DRAIN_CHECKSUM_EN
    .out_checksum(out_checksum),
`endif
    .done        (done)
  );

  always #5 m_clk = ~m_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge m_clk);
    #1;
  endtask

  // mode 0: C(r,c)=r*16+c, 1: random, else constant k
  task automatic fill_frame(input int mode, input logic [DW-1:0] k);
    for (int i = 0; i < NN; i++) begin
      logic [DW-1:0] v;
      case (mode)
        0:       v = DW'((i / N) * 16 + (i % N));
        1:       v = DW'($urandom);
        default: v = k;
      endcase
      c_flat[DW*i +: DW] = v;
      exp_mem[i] = v;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Returns index of first beat deviating from the model, or -1.
  function automatic int first_bad();
    for (int k = 0; k < bq_data.size() && k < NN; k++)
      if (bq_data[k] !== exp_mem[k] || bq_row[k] != k / N || bq_col[k] != k % N ||
          bq_last[k] != (k == NN - 1))
        return k;
    return -1;
  endfunction

  // ready mode 0: always, 1: random, else stall 3 cycles on element (2,5)
  task automatic collect(input int mode, input int st_lo, input int st_hi);
    logic [DW+2*LN:0] hv = '0;
    bit hold = 1'b0;
    int stall = 0;
    bq_data.delete(); bq_row.delete(); bq_col.delete(); bq_last.delete();
    done_cyc = -1; done_cnt = 0; stab_err = 0; stall_hits = 0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: begin
          if (out_valid && out_row == 2 && out_col == 5 && stall < 3) begin
            out_ready = 1'b0;
            stall++;
          end else out_ready = 1'b1;
        end
      endcase
      start = (cyc >= st_lo && cyc <= st_hi);
      if (hold && out_valid && {out_data, out_row, out_col, out_last} !== hv) stab_err++;
      hold = out_valid && !out_ready;
      hv = {out_data, out_row, out_col, out_last};
      if (out_valid && !out_ready && out_data == 16'h0025) stall_hits++;
      if (out_valid && out_ready) begin
        bq_data.push_back(out_data);
        bq_row.push_back(int'(out_row));
        bq_col.push_back(int'(out_col));
        bq_last.push_back(out_last);
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
`ifdef RESULT_DRAIN_CHECKSUM_EN
          cs_at_done = out_checksum;
`endif
        end
      end
      tick();
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (out_row !== '0 || out_col !== '0) begin errors++; $display("FAIL reset_rowcol: got %0d,%0d want 0,0", out_row, out_col); end
    checks++; if (out_data !== '0 || out_last !== 1'b0) begin errors++; $display("FAIL reset_data: got %h/%b want 0/0", out_data, out_last); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_full_frame();
    int idle_bad = 0;
    fill_frame(0, '0);
    pulse_start();
    checks++; if (out_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL first_beat_latency: got valid=%b busy=%b want 1,1", out_valid, busy); end
    collect(0, 65, 65);
    checks++; if (bq_data.size() != NN) begin errors++; $display("FAIL full_count: got %0d want %0d", bq_data.size(), NN); end
    checks++; if (first_bad() != -1) begin errors++; $display("FAIL full_order: got bad beat %0d want -1", first_bad()); end
    checks++; if (done_cyc != 65) begin errors++; $display("FAIL full_done_cycle: got %0d want 65", done_cyc); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL full_done_pulse: got %0d want 1", done_cnt); end
    repeat (5) begin
      if (out_valid || busy) idle_bad++;
      tick();
    end
    checks++; if (idle_bad != 0) begin errors++; $display("FAIL start_in_done_ignored: got %0d busy cycles want 0", idle_bad); end
  endtask

  task automatic test_backpressure();
    fill_frame(0, '0);
    pulse_start();
    collect(2, 0, -1);
    checks++; if (bq_data.size() != NN) begin errors++; $display("FAIL bp_count: got %0d want %0d", bq_data.size(), NN); end
    checks++; if (first_bad() != -1) begin errors++; $display("FAIL bp_order: got bad beat %0d want -1", first_bad()); end
    checks++; if (stall_hits != 3) begin errors++; $display("FAIL bp_hold_0x25: got %0d stalled cycles want 3", stall_hits); end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL bp_stable: got %0d changes want 0", stab_err); end
    checks++; if (done_cyc != 68) begin errors++; $display("FAIL bp_done_cycle: got %0d want 68", done_cyc); end
    for (int f = 0; f < 3; f++) begin
      fill_frame(1, '0);
      pulse_start();
      collect(1, 0, -1);
      checks++; if (bq_data.size() != NN || first_bad() != -1) begin errors++; $display("FAIL rand_frame%0d: got count=%0d bad=%0d want %0d,-1", f, bq_data.size(), first_bad(), NN); end
      checks++; if (stab_err != 0 || done_cnt != 1) begin errors++; $display("FAIL rand_hold%0d: got changes=%0d done=%0d want 0,1", f, stab_err, done_cnt); end
    end
  endtask

  task automatic test_snapshot();
    int extra = 0;
    fill_frame(0, '0);
    pulse_start();
    c_flat = '1;
    collect(0, 20, 20);
    checks++; if (bq_data.size() != NN || first_bad() != -1) begin errors++; $display("FAIL snap_frame: got count=%0d bad=%0d want %0d,-1", bq_data.size(), first_bad(), NN); end
    checks++; if (done_cyc != 65) begin errors++; $display("FAIL snap_done_cycle: got %0d want 65", done_cyc); end
    repeat (20) begin
      if (out_valid) extra++;
      tick();
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL midstream_start_ignored: got %0d valid cycles want 0", extra); end
    fill_frame(1, '0);
    start = 1'b1;
    tick();
    collect(0, 1, 2);
    checks++; if (bq_data.size() != NN || first_bad() != -1 || done_cnt != 1) begin errors++; $display("FAIL held_start: got count=%0d bad=%0d done=%0d want %0d,-1,1", bq_data.size(), first_bad(), done_cnt, NN); end
    repeat (10) begin
      if (out_valid) extra++;
      tick();
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL held_start_single: got %0d valid cycles want 0", extra); end
  endtask

  task automatic test_reset_midstream();
    int bad = 0;
    fill_frame(1, '0);
    pulse_start();
    out_ready = 1'b1;
    repeat (30) tick();
    checks++; if (out_data !== exp_mem[30] || out_row !== 3'd3 || out_col !== 3'd6) begin errors++; $display("FAIL beat30: got %h@%0d,%0d want %h@3,6", out_data, out_row, out_col, exp_mem[30]); end
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0 || out_row !== '0) begin errors++; $display("FAIL abort_reset: got valid=%b busy=%b data=%h row=%0d want 0,0,0,0", out_valid, busy, out_data, out_row); end
    tick(); tick();
    rst = 1'b0;
    repeat (5) begin
      if (done || out_valid) bad++;
      tick();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL abort_no_done: got %0d active cycles want 0", bad); end
    fill_frame(1, '0);
    pulse_start();
    collect(1, 0, -1);
    checks++; if (bq_data.size() != NN || first_bad() != -1 || done_cnt != 1) begin errors++; $display("FAIL after_abort: got count=%0d bad=%0d done=%0d want %0d,-1,1", bq_data.size(), first_bad(), done_cnt, NN); end
  endtask

`ifdef RESULT_DRAIN_CHECKSUM_EN
  task automatic test_checksum();
    logic [DW-1:0] sum;
    fill_frame(2, 16'h0401);
    pulse_start();
    checks++; if (out_checksum !== '0) begin errors++; $display("FAIL cs_clear: got %h want 0000", out_checksum); end
    collect(0, 0, -1);
    checks++; if (cs_at_done !== 16'h0040) begin errors++; $display("FAIL cs_0401: got %h want 0040", cs_at_done); end
    checks++; if (out_checksum !== 16'h0040) begin errors++; $display("FAIL cs_stable: got %h want 0040", out_checksum); end
    fill_frame(2, 16'h1000);
    pulse_start();
    collect(1, 0, -1);
    checks++; if (cs_at_done !== 16'h0000) begin errors++; $display("FAIL cs_wrap: got %h want 0000", cs_at_done); end
    fill_frame(1, '0);
    sum = '0;
    for (int i = 0; i < NN; i++) sum = sum + exp_mem[i];
    pulse_start();
    collect(1, 0, -1);
    checks++; if (cs_at_done !== sum) begin errors++; $display("FAIL cs_random: got %h want %h", cs_at_done, sum); end
  endtask
`endif

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_snapshot();
    test_reset_midstream();
`ifdef RESULT_DRAIN_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
